serial_adder: RTL and testbench

//  Bit-serial adder that feeds one full-adder slice per clock from two shift

---
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice per cycle, LSB first, registered carry; optional SERIAL_ADDER_OVF_EN adds signed overflow.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and the result is held until the next accepted start.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_shift;
    logic             c, s, c_nxt, last_slice;
    logic [CW-1:0]    cnt;

    assign s          = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nxt      = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign last_slice = (cnt == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; written this way it also holds for WIDTH=1.
    assign s_shift    = (s_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_slice) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a_in;
                        b_sr <= b_in;
                        c    <= cin;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_shift;
                    c    <= c_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_slice) begin
                        sum  <= s_shift;
                        cout <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB slice is the carry register during the last slice.
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ovf_q <= 1'b0;
        else if (state == ADD && last_slice) ovf_q <= c ^ c_nxt;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a timeline/arithmetic model, plus hand-computed directed cases.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       start0 = 1'b0, cin0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, sum0;
    logic       busy0, done0, cout0, ovf0;
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       busy1, done1, cout1, ovf1;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_in(a0), .b_in(b0), .cin(cin0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

    // ---------------- reference model ----------------
    function automatic int add_res(int w, int a, int b, int c);
        return (a + b + c) % (1 << (w + 1));
    endfunction

    function automatic bit add_ovf(int w, int a, int b, int c);
        int sa, sb, ss;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        ss = sa + sb + c;
`ifdef SERIAL_ADDER_OVF_EN
        return (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
`else
        return (ss > 0) && (ss < 0);
`endif
    endfunction

    bit m_busy[2], m_done[2], m_ovf[2], p_ovf[2], st[2];
    int m_age[2], m_res[2], p_res[2], ia[2], ib[2], ic[2], wd[2];

    always_comb begin
        st[0] = start0; ia[0] = int'(a0); ib[0] = int'(b0); ic[0] = int'(cin0); wd[0] = 8;
        st[1] = start1; ia[1] = int'(a1); ib[1] = int'(b1); ic[1] = int'(cin1); wd[1] = 1;
    end

    // Timeline: accepted at edge k, result at edge k+w, idle again at edge k+w+1.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_age[i] <= 0;
                m_res[i]  <= 0;    m_ovf[i]  <= 1'b0;
            end else if (m_busy[i]) begin
                m_age[i] <= m_age[i] + 1;
                if (m_age[i] == wd[i] - 1) begin
                    m_res[i] <= p_res[i]; m_ovf[i] <= p_ovf[i]; m_done[i] <= 1'b1;
                end
                if (m_age[i] == wd[i]) begin
                    m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
                end
            end else if (st[i]) begin
                m_busy[i] <= 1'b1;
                m_age[i]  <= 0;
                p_res[i]  <= add_res(wd[i], ia[i], ib[i], ic[i]);
                p_ovf[i]  <= add_ovf(wd[i], ia[i], ib[i], ic[i]);
            end
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({busy0, done0, cout0, ovf0, sum0} !==
            {m_busy[0], m_done[0], m_res[0][8], m_ovf[0], m_res[0][7:0]}) begin
            n_bad++;
            $display("FAIL model_w8 t=%0t: got busy=%b done=%b cout=%b ovf=%b sum=%h, want busy=%b done=%b cout=%b ovf=%b sum=%h",
                     $time, busy0, done0, cout0, ovf0, sum0,
                     m_busy[0], m_done[0], m_res[0][8], m_ovf[0], m_res[0][7:0]);
        end
        n_cmp++;
        if ({busy1, done1, cout1, ovf1, sum1} !==
            {m_busy[1], m_done[1], m_res[1][1], m_ovf[1], m_res[1][0]}) begin
            n_bad++;
            $display("FAIL model_w1 t=%0t: got busy=%b done=%b cout=%b ovf=%b sum=%b, want busy=%b done=%b cout=%b ovf=%b sum=%b",
                     $time, busy1, done1, cout1, ovf1, sum1,
                     m_busy[1], m_done[1], m_res[1][1], m_ovf[1], m_res[1][0]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input int exp_sum, input int exp_cout, input int exp_ovf);
        int g, t;
        g = 0;
        while (busy0 && g < 50) begin tick(); g++; end
        chk({nm, "_idle"}, int'(busy0), 0);
        start0 = 1'b1; a0 = a; b0 = b; cin0 = c;
        tick();
        start0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
        t = 0;
        while (!done0 && t < 40) begin tick(); t++; end
        chk({nm, "_lat"}, t, 8);
        chk({nm, "_sum"}, int'(sum0), exp_sum);
        chk({nm, "_cout"}, int'(cout0), exp_cout);
        chk({nm, "_ovf"}, int'(ovf0), exp_ovf);
    endtask

    task automatic op1(input logic [2:0] v);
        int t;
        start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
        tick();
        start1 = 1'b0;
        t = 0;
        while (!done1 && t < 10) begin tick(); t++; end
        chk("w1_lat", t, 1);
        chk("w1_sum", int'(sum1), int'(v[2] ^ v[1] ^ v[0]));
        chk("w1_cout", int'(cout1), int'((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])));
        tick();
    endtask

    initial begin
        int pulses;
        #1 rst_n = 1'b0;
        chk("reset_state", int'({busy0, done0, cout0, ovf0, sum0}), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        op8("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 0, 0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1, 0);
`ifdef SERIAL_ADDER_OVF_EN
        op8("add_7f_01_c", 8'h7F, 8'h01, 1'b1, 8'h81, 0, 1);
`else
        op8("add_7f_01_c", 8'h7F, 8'h01, 1'b1, 8'h81, 0, 0);
`endif

        // Second start during ADD must be ignored.
        tick(); tick();
        start0 = 1'b1; a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0;
        tick();
        start0 = 1'b0;
        tick(); tick();
        start0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
        tick();
        start0 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (done0) begin
                pulses++;
                chk("ignore_busy_sum", int'(sum0), 8'h30);
            end
            tick();
        end
        chk("ignore_busy_pulses", pulses, 1);
        chk("ignore_busy_idle", int'(busy0), 0);

        // Reset in the middle of an addition discards it.
        start0 = 1'b1; a0 = 8'hAA; b0 = 8'h55; cin0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midop_reset", int'({busy0, done0, cout0, ovf0, sum0}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        op8("after_reset", 8'h01, 8'h02, 1'b1, 8'h04, 0, 0);

        for (int v = 0; v < 8; v++) op1(3'(v));

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start0 = ($urandom_range(0, 3) == 0);
            a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom);
            start1 = ($urandom_range(0, 2) == 0);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
